// File: rtl/flags_ctx_unit.sv
`default_nettype none
// ============================================================================
// Module   : flags_ctx_unit
// Purpose  : 8086 status-flags register with a shadow stack for interrupt
//            entry/return, the one-instruction interrupt shadow that follows
//            a 0->1 change of IF, and single-step trap sequencing from TF.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           system clock, all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   flags_in      candidate flag values at 8086 bit positions
//   update_flags  per-flag write enable [0]C [1]P [2]A [3]Z [4]S [5]T [6]I
//                 [7]D [8]O
//   save          interrupt entry: push flags, clear IF and TF
//   restore       interrupt return: pop the top entry into all nine flags
//   instr_done    one-cycle pulse at each instruction retirement
//   flags_out     {4'b0, O, D, I, T, S, Z, 0, A, 0, P, 1, C}
//   irq_enable    maskable interrupts may be taken (IF and no shadow)
//   trap_pending  single-step trap requested
//   depth         number of valid stack entries
//   overflow      sticky: save attempted with the stack full
//   underflow     sticky: restore attempted with the stack empty
// ============================================================================
module flags_ctx_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   flags_in,
  input  logic [8:0]    update_flags,
  input  logic          save,
  input  logic          restore,
  input  logic          instr_done,
  output logic [15:0]   flags_out,
  output logic          irq_enable,
  output logic          trap_pending,
  output logic [DW-1:0] depth,
  output logic          overflow,
  output logic          underflow
);

  // Compact flag vector index, same order as update_flags.
  localparam int F_C = 0;
  localparam int F_P = 1;
  localparam int F_A = 2;
  localparam int F_Z = 3;
  localparam int F_S = 4;
  localparam int F_T = 5;
  localparam int F_I = 6;
  localparam int F_D = 7;
  localparam int F_O = 8;

  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [8:0] flags;                        // architectural flags
  logic [8:0] stack_mem [STACK_DEPTH];      // saved flag words
  logic       sti_shadow;
  logic       tf_armed;

  // --------------------------------------------------------------------------
  // Combinational next-state
  // --------------------------------------------------------------------------
  logic [8:0]    in_flags;     // flags_in gathered into compact order
  logic [8:0]    upd_flags;    // normal-update result
  logic [8:0]    top_flags;    // entry[depth-1]
  logic [8:0]    next_flags;
  logic          stack_full;
  logic          stack_empty;
  logic          conflict;
  logic          do_push;
  logic          do_pop;
  logic          do_ovf;
  logic          do_unf;
  logic          normal_path;
  logic          next_shadow;

  // Bits of flags_in that carry no flag.
  logic unused_flag_bits;
  assign unused_flag_bits = ^{flags_in[15:12], flags_in[5], flags_in[3], flags_in[1]};

  always_comb begin
    in_flags = '0;
    in_flags[F_C] = flags_in[0];
    in_flags[F_P] = flags_in[2];
    in_flags[F_A] = flags_in[4];
    in_flags[F_Z] = flags_in[6];
    in_flags[F_S] = flags_in[7];
    in_flags[F_T] = flags_in[8];
    in_flags[F_I] = flags_in[9];
    in_flags[F_D] = flags_in[10];
    in_flags[F_O] = flags_in[11];
  end

  assign upd_flags   = (update_flags & in_flags) | (~update_flags & flags);
  assign stack_full  = (depth == FULL_DEPTH);
  assign stack_empty = (depth == '0);

  // Simultaneous save and restore cancel each other; only the normal update
  // survives and both error flags record the attempt.
  assign conflict    = save & restore;
  assign do_push     = save & ~restore & ~stack_full;
  assign do_ovf      = save & ~restore &  stack_full;
  assign do_pop      = restore & ~save & ~stack_empty;
  assign do_unf      = restore & ~save &  stack_empty;
  assign normal_path = conflict | (~save & ~restore);

  // Read mux for the top of stack, written as a compare chain so that the
  // depth counter (which can equal STACK_DEPTH) never indexes the array.
  always_comb begin
    top_flags = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      if (depth == DW'(k + 1)) begin
        top_flags = stack_mem[k];
      end
    end
  end

  always_comb begin
    next_flags = flags;
    if (normal_path) begin
      next_flags = upd_flags;
    end else if (do_push) begin
      next_flags      = upd_flags;
      next_flags[F_I] = 1'b0;
      next_flags[F_T] = 1'b0;
    end else if (do_pop) begin
      next_flags = top_flags;
    end
  end

  // Shadow: set by a 0->1 change of IF on the normal path (which outranks a
  // coincident instr_done, so clearing always needs a later retirement);
  // dropped on retirement, whenever IF ends up 0, or on any stack operation.
  always_comb begin
    next_shadow = sti_shadow;
    if (instr_done) begin
      next_shadow = 1'b0;
    end
    if (!next_flags[F_I]) begin
      next_shadow = 1'b0;
    end
    if (normal_path && !flags[F_I] && upd_flags[F_I]) begin
      next_shadow = 1'b1;
    end
    if (do_push || do_pop) begin
      next_shadow = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags        <= '0;
      depth        <= '0;
      sti_shadow   <= 1'b0;
      tf_armed     <= 1'b0;
      trap_pending <= 1'b0;
      irq_enable   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        stack_mem[k] <= '0;
      end
    end else begin
      flags      <= next_flags;
      sti_shadow <= next_shadow;
      irq_enable <= next_flags[F_I] & ~next_shadow;

      if (do_push) begin
        for (int k = 0; k < STACK_DEPTH; k++) begin
          if (depth == DW'(k)) begin
            stack_mem[k] <= flags;
          end
        end
        depth <= depth + DW'(1);
      end else if (do_pop) begin
        depth <= depth - DW'(1);
      end

      // Trap sequencing samples TF before this cycle's update; a successful
      // save overrides whatever the retirement would have done.
      if (do_push) begin
        tf_armed     <= 1'b0;
        trap_pending <= 1'b0;
      end else if (instr_done) begin
        tf_armed <= flags[F_T];
        if (tf_armed) begin
          trap_pending <= 1'b1;
        end
      end

      if (do_ovf || conflict) begin
        overflow <= 1'b1;
      end
      if (do_unf || conflict) begin
        underflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output packing
  // --------------------------------------------------------------------------
  assign flags_out = {4'b0000, flags[F_O], flags[F_D], flags[F_I], flags[F_T],
                      flags[F_S], flags[F_Z], 1'b0, flags[F_A], 1'b0,
                      flags[F_P], 1'b1, flags[F_C]};

endmodule
`default_nettype wire

// File: tb/tb_flags_ctx_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flags_ctx_unit
// Purpose  : Self-checking bench for flags_ctx_unit (STACK_DEPTH = 2).
//            Vector table driven through a scoreboard queue, plus a
//            hand-written asynchronous reset sequence mid-stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flags_ctx_unit;

  localparam int SD = 2;
  localparam int DW = $clog2(SD + 1);

  logic          clk;
  logic          reset;
  logic [15:0]   flags_in;
  logic [8:0]    update_flags;
  logic          save;
  logic          restore;
  logic          instr_done;
  logic [15:0]   flags_out;
  logic          irq_enable;
  logic          trap_pending;
  logic [DW-1:0] depth;
  logic          overflow;
  logic          underflow;

  flags_ctx_unit #(.STACK_DEPTH(SD), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flags_in     (flags_in),
    .update_flags (update_flags),
    .save         (save),
    .restore      (restore),
    .instr_done   (instr_done),
    .flags_out    (flags_out),
    .irq_enable   (irq_enable),
    .trap_pending (trap_pending),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fin;
    logic [8:0]  upd;
    logic        sv;
    logic        rs;
    logic        id;
    logic [15:0] e_flags;
    logic        e_irq;
    logic        e_trap;
    logic [1:0]  e_depth;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] e_flags;
    logic        e_irq;
    logic        e_trap;
    logic [1:0]  e_depth;
    logic        e_ovf;
    logic        e_unf;
  } exp_t;

  vec_t vecs [25];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic [15:0] fin, logic [8:0] upd, logic sv,
                              logic rs, logic id, logic [15:0] ef, logic ei,
                              logic et, logic [1:0] ed, logic eo, logic eu);
    vec_t v;
    v.fin = fin; v.upd = upd; v.sv = sv; v.rs = rs; v.id = id;
    v.e_flags = ef; v.e_irq = ei; v.e_trap = et; v.e_depth = ed;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, required %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("flags_out",    e.idx, flags_out,              e.e_flags);
    chk("irq_enable",   e.idx, {15'b0, irq_enable},    {15'b0, e.e_irq});
    chk("trap_pending", e.idx, {15'b0, trap_pending},  {15'b0, e.e_trap});
    chk("depth",        e.idx, {{(16-DW){1'b0}}, depth}, {14'b0, e.e_depth});
    chk("overflow",     e.idx, {15'b0, overflow},      {15'b0, e.e_ovf});
    chk("underflow",    e.idx, {15'b0, underflow},     {15'b0, e.e_unf});
  endtask

  task automatic idle_inputs();
    flags_in = '0; update_flags = '0; save = 1'b0; restore = 1'b0;
    instr_done = 1'b0;
  endtask

  // Drive one vector, queue its expectation, sample 1 time unit after the edge.
  task automatic apply(input int idx);
    exp_t e;
    flags_in     = vecs[idx].fin;
    update_flags = vecs[idx].upd;
    save         = vecs[idx].sv;
    restore      = vecs[idx].rs;
    instr_done   = vecs[idx].id;
    e.idx = idx; e.e_flags = vecs[idx].e_flags; e.e_irq = vecs[idx].e_irq;
    e.e_trap = vecs[idx].e_trap; e.e_depth = vecs[idx].e_depth;
    e.e_ovf = vecs[idx].e_ovf; e.e_unf = vecs[idx].e_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    idle_inputs();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 16'h0, 16'h1);
    end else begin
      check_all(sb.pop_front());
    end
  endtask

  initial begin
    exp_t r;
    //                fin       upd     sv rs id  flags    irq trp d  ov un
    // basic update, shadow, trap arming
    vecs[0]  = mk(16'h0FD5, 9'h1FF, 0, 0, 0, 16'h0FD7, 0, 0, 0, 0, 0);
    vecs[1]  = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0FD7, 1, 0, 0, 0, 0);
    vecs[2]  = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0FD7, 1, 1, 0, 0, 0);
    vecs[3]  = mk(16'h0000, 9'h000, 1, 0, 0, 16'h0CD7, 0, 0, 1, 0, 0);
    vecs[4]  = mk(16'h0000, 9'h000, 0, 1, 0, 16'h0FD7, 1, 0, 0, 0, 0);
    vecs[5]  = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0FD7, 1, 0, 0, 0, 0);
    // save coinciding with instr_done while tf_armed: save wins
    vecs[6]  = mk(16'h0000, 9'h000, 1, 0, 1, 16'h0CD7, 0, 0, 1, 0, 0);
    // round-trip of 0AD7 on top of a second entry
    vecs[7]  = mk(16'h0AD7, 9'h1FF, 0, 0, 0, 16'h0AD7, 0, 0, 1, 0, 0);
    vecs[8]  = mk(16'h0000, 9'h000, 1, 0, 0, 16'h08D7, 0, 0, 2, 0, 0);
    // save when full: update ignored, overflow sticky
    vecs[9]  = mk(16'h0000, 9'h1FF, 1, 0, 0, 16'h08D7, 0, 0, 2, 1, 0);
    vecs[10] = mk(16'h0000, 9'h000, 0, 1, 0, 16'h0AD7, 1, 0, 1, 1, 0);
    vecs[11] = mk(16'h0000, 9'h000, 0, 1, 0, 16'h0FD7, 1, 0, 0, 1, 0);
    // restore when empty: update ignored
    vecs[12] = mk(16'h0000, 9'h1FF, 0, 1, 0, 16'h0FD7, 1, 0, 0, 1, 1);
    // save+restore conflict: normal update applies (C=1, P=0)
    vecs[13] = mk(16'h0001, 9'h003, 1, 1, 0, 16'h0FD3, 1, 0, 0, 1, 1);
    // clear IF, then set IF together with instr_done: shadow survives it
    vecs[14] = mk(16'h0000, 9'h040, 0, 0, 0, 16'h0DD3, 0, 0, 0, 1, 1);
    vecs[15] = mk(16'h0200, 9'h040, 0, 0, 1, 16'h0FD3, 0, 0, 0, 1, 1);
    vecs[16] = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0FD3, 1, 1, 0, 1, 1);
    vecs[17] = mk(16'h0000, 9'h000, 0, 0, 0, 16'h0FD3, 1, 1, 0, 1, 1);
    // two saves with T re-armed afterwards
    vecs[18] = mk(16'h0000, 9'h000, 1, 0, 0, 16'h0CD3, 0, 0, 1, 1, 1);
    vecs[19] = mk(16'h0100, 9'h020, 0, 0, 0, 16'h0DD3, 0, 0, 1, 1, 1);
    vecs[20] = mk(16'h0000, 9'h000, 1, 0, 0, 16'h0CD3, 0, 0, 2, 1, 1);
    vecs[21] = mk(16'h0100, 9'h020, 0, 0, 0, 16'h0DD3, 0, 0, 2, 1, 1);
    vecs[22] = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0DD3, 0, 0, 2, 1, 1);
    // after the asynchronous reset
    vecs[23] = mk(16'h0000, 9'h000, 0, 0, 1, 16'h0002, 0, 0, 0, 0, 0);
    vecs[24] = mk(16'h0000, 9'h000, 0, 1, 0, 16'h0002, 0, 0, 0, 0, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    r.idx = -1; r.e_flags = 16'h0002; r.e_irq = 0; r.e_trap = 0;
    r.e_depth = 0; r.e_ovf = 0; r.e_unf = 0;
    check_all(r);
    @(posedge clk);
    #1;

    for (int i = 0; i <= 22; i++) begin
      apply(i);
    end

    // Asynchronous reset between edges with two entries stacked and T armed.
    #2;
    reset = 1'b1;
    #1;
    r.idx = 100;
    check_all(r);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    r.idx = 101;
    check_all(r);

    for (int i = 23; i <= 24; i++) begin
      apply(i);
    end

    if (sb.size() != 0) begin
      chk("scoreboard_leftover", 0, 16'(sb.size()), 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
